// File: rtl/ts_packet_sender_if.sv
// Buffer write port and MPEG-TS byte stream of ts_packet_sender.
// The master side loads the buffer and observes the stream.
interface ts_packet_sender_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
    logic                            wr_en;
    logic [5:0]                      wr_index;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic [7:0]                      mpeg_data;
    logic                            mpeg_valid;
    logic                            mpeg_sync;

    modport master (
        output wr_en, wr_index, wr_data, wr_strb,
        input  mpeg_data, mpeg_valid, mpeg_sync
    );

    modport slave (
        input  wr_en, wr_index, wr_data, wr_strb,
        output mpeg_data, mpeg_valid, mpeg_sync
    );
endinterface

// File: rtl/ts_packet_sender.sv
// Replays one 188-byte TS packet held in a 47-word buffer as a paced
// mpeg_data/mpeg_valid/mpeg_sync stream, with inter-packet gaps and repetition.
module ts_packet_sender #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    ts_packet_sender_if.slave    bus,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          repeat_count,
    input  logic [7:0]           byte_div,
    input  logic [7:0]           gap_bytes,
    output logic                 busy,
    output logic                 wr_err,
    output logic [31:0]          packets_sent
);

    typedef enum logic [1:0] {Idle, Send, Gap} state_e;

    state_e                        state;
    logic [C_S_AXI_DATA_WIDTH-1:0] mem [47];
    logic [7:0]                    byte_idx;
    logic [7:0]                    div_cnt;
    logic [7:0]                    gap_cnt;
    logic [15:0]                   repeat_l;
    logic [7:0]                    byte_div_l;
    logic [7:0]                    gap_l;
    logic                          stop_pend;
    logic [7:0]                    mpeg_data_q;
    logic                          mpeg_valid_q;
    logic                          mpeg_sync_q;

    logic                          wr_ok;
    logic                          slot_end;
    logic                          stop_now;
    logic                          last_pkt;
    logic [31:0]                   sent_inc;
    logic [7:0]                    rd_idx;
    logic [7:0]                    rd_byte;

    assign bus.mpeg_data  = mpeg_data_q;
    assign bus.mpeg_valid = mpeg_valid_q;
    assign bus.mpeg_sync  = mpeg_sync_q;

    assign wr_ok = bus.wr_en && (state == Idle) && (bus.wr_index < 6'd47);

    // rd_idx is the byte that goes out at the next slot boundary.
    always_comb begin
        slot_end = (div_cnt == byte_div_l);
        stop_now = stop_pend | stop;
        sent_inc = packets_sent + 32'd1;
        last_pkt = (repeat_l != 16'd0) && (sent_inc == {16'd0, repeat_l});
        rd_idx   = (state == Send && byte_idx != 8'd187) ? byte_idx + 8'd1 : 8'd0;
        rd_byte  = mem[rd_idx[7:2]][{rd_idx[1:0], 3'b000} +: 8];
    end

    // Buffer has no reset; contents are undefined until software loads it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_ok) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                if (bus.wr_strb[b]) begin
                    mem[bus.wr_index][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state        <= Idle;
            byte_idx     <= 8'd0;
            div_cnt      <= 8'd0;
            gap_cnt      <= 8'd0;
            repeat_l     <= 16'd0;
            byte_div_l   <= 8'd0;
            gap_l        <= 8'd0;
            stop_pend    <= 1'b0;
            busy         <= 1'b0;
            wr_err       <= 1'b0;
            packets_sent <= 32'd0;
            mpeg_data_q  <= 8'd0;
            mpeg_valid_q <= 1'b0;
            mpeg_sync_q  <= 1'b0;
        end else begin
            wr_err       <= bus.wr_en && (state != Idle);
            mpeg_valid_q <= 1'b0;
            mpeg_sync_q  <= 1'b0;
            unique case (state)
                Idle: begin
                    // A stop arriving with start is dropped.
                    if (start) begin
                        repeat_l     <= repeat_count;
                        byte_div_l   <= byte_div;
                        gap_l        <= gap_bytes;
                        packets_sent <= 32'd0;
                        stop_pend    <= 1'b0;
                        byte_idx     <= 8'd0;
                        div_cnt      <= 8'd0;
                        busy         <= 1'b1;
                        mpeg_data_q  <= rd_byte;
                        mpeg_valid_q <= 1'b1;
                        mpeg_sync_q  <= 1'b1;
                        state        <= Send;
                    end
                end
                Send: begin
                    if (stop) stop_pend <= 1'b1;
                    if (!slot_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (byte_idx != 8'd187) begin
                            byte_idx     <= byte_idx + 8'd1;
                            mpeg_data_q  <= rd_byte;
                            mpeg_valid_q <= 1'b1;
                        end else begin
                            packets_sent <= sent_inc;
                            byte_idx     <= 8'd0;
                            if (stop_now || last_pkt) begin
                                state     <= Idle;
                                busy      <= 1'b0;
                                stop_pend <= 1'b0;
                            end else if (gap_l != 8'd0) begin
                                state   <= Gap;
                                gap_cnt <= 8'd0;
                            end else begin
                                mpeg_data_q  <= rd_byte;
                                mpeg_valid_q <= 1'b1;
                                mpeg_sync_q  <= 1'b1;
                            end
                        end
                    end
                end
                Gap: begin
                    if (stop) stop_pend <= 1'b1;
                    if (!slot_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (stop_now) begin
                            state     <= Idle;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else if (gap_cnt == gap_l - 8'd1) begin
                            state        <= Send;
                            mpeg_data_q  <= rd_byte;
                            mpeg_valid_q <= 1'b1;
                            mpeg_sync_q  <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_packet_sender.sv
// Bench for ts_packet_sender: drives directed and random packet runs and checks
// every emitted byte's cycle, value and sync against a packet/slot arithmetic model.
module tb_ts_packet_sender;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       s;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] repeat_count;
    logic [7:0]  byte_div;
    logic [7:0]  gap_bytes;
    logic        busy;
    logic        wr_err;
    logic [31:0] packets_sent;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [188];
    ev_t         evq[$];

    ts_packet_sender_if #(.C_S_AXI_DATA_WIDTH(32)) bus ();

    ts_packet_sender #(.C_S_AXI_DATA_WIDTH(32)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus),
        .start         (start),
        .stop          (stop),
        .repeat_count  (repeat_count),
        .byte_div      (byte_div),
        .gap_bytes     (gap_bytes),
        .busy          (busy),
        .wr_err        (wr_err),
        .packets_sent  (packets_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mpeg_valid === 1'b1) evq.push_back('{cyc, bus.mpeg_data, bus.mpeg_sync});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int idx, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_index = 6'(idx);
        bus.wr_data  = data;
        bus.wr_strb  = strb;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("wr_err_idle", {63'd0, wr_err}, 64'd0);
        if (idx < 47) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[4*idx+b] = data[8*b +: 8];
        end
    endtask

    task automatic load_model();
        for (int w = 0; w < 47; w++)
            write_word(w, {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]}, 4'hf);
    endtask

    task automatic randomize_model();
        for (int i = 0; i < 188; i++) model[i] = 8'($urandom);
        load_model();
    endtask

    // Run one transmission. stop_off/inj_off are cycle offsets from the first byte
    // (-1 = none); inj writes a word and re-pulses start while busy.
    task automatic run(input string tag, input int rep, input int div, input int gap,
                       input int stop_off, input int inj_off, input bit both);
        int t0, npk, per, period, guard, limit, t_exp, inj_phase, p, k, sslot;
        per    = div + 1;
        period = 188 + gap;
        npk    = (rep == 0) ? 1000 : rep;
        t_exp  = -1;
        if (stop_off >= 0) begin
            sslot = stop_off / per;
            if (sslot / period + 1 < npk) npk = sslot / period + 1;
            if (sslot % period >= 188) t_exp = (sslot + 1) * per;
        end
        if (t_exp < 0) t_exp = (npk * period - gap) * per;
        @(negedge clk);
        repeat_count = 16'(rep);
        byte_div     = 8'(div);
        gap_bytes    = 8'(gap);
        start        = 1'b1;
        stop         = both;
        evq.delete();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        t0    = cyc;
        repeat_count = 16'($urandom_range(1, 3));
        byte_div     = 8'($urandom_range(0, 7));
        gap_bytes    = 8'($urandom_range(0, 7));
        chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        limit = t_exp + 50;
        guard = 0;
        inj_phase = 0;
        while (busy === 1'b1 && guard < limit) begin
            if (cyc - t0 == stop_off) stop = 1'b1;
            if (cyc - t0 == inj_off) begin
                bus.wr_en    = 1'b1;
                bus.wr_index = 6'($urandom_range(0, 46));
                bus.wr_data  = $urandom;
                bus.wr_strb  = 4'hf;
                start        = 1'b1;
                inj_phase    = 1;
            end
            @(negedge clk);
            stop      = 1'b0;
            start     = 1'b0;
            bus.wr_en = 1'b0;
            if (inj_phase == 1) begin
                chk({tag, "_wr_err_pulse"}, {63'd0, wr_err}, 64'd1);
                inj_phase = 2;
            end else if (inj_phase == 2) begin
                chk({tag, "_wr_err_clear"}, {63'd0, wr_err}, 64'd0);
                inj_phase = 3;
            end
            guard++;
        end
        chk({tag, "_busy_fall_cycle"}, 64'(cyc - t0), 64'(t_exp));
        chk({tag, "_packets_sent"}, {32'd0, packets_sent}, 64'(npk));
        chk({tag, "_byte_count"}, 64'(evq.size()), 64'(npk * 188));
        for (int i = 0; i < evq.size() && i < npk * 188; i++) begin
            p = i / 188;
            k = i % 188;
            chk($sformatf("%s_byte%0d", tag, i), 64'({evq[i].c - t0, evq[i].d, evq[i].s}),
                64'({(p * period + k) * per, model[k], k == 0}));
        end
    endtask

    initial begin
        int t0, guard, nvalid;
        rst_n        = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        repeat_count = 16'd0;
        byte_div     = 8'd0;
        gap_bytes    = 8'd0;
        bus.wr_en    = 1'b0;
        bus.wr_index = 6'd0;
        bus.wr_data  = 32'd0;
        bus.wr_strb  = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, bus.mpeg_valid}, 64'd0);
        chk("rst_sync", {63'd0, bus.mpeg_sync}, 64'd0);
        chk("rst_data", {56'd0, bus.mpeg_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_wr_err", {63'd0, wr_err}, 64'd0);
        chk("rst_packets", {32'd0, packets_sent}, 64'd0);
        rst_n = 1'b1;

        // Counting pattern, back-to-back bytes.
        for (int i = 0; i < 188; i++) model[i] = (i == 0) ? 8'h47 : 8'(i);
        load_model();
        run("t1", 1, 0, 0, -1, -1, 1'b0);

        run("t2", 2, 3, 2, -1, -1, 1'b0);

        // Continuous, stop at byte 100 of the third packet.
        run("t3", 0, 1, 3, (2 * 191 + 100) * 2, -1, 1'b0);

        // Partial-strobe write over an existing word; out-of-range index ignored.
        write_word(5, 32'h11223344, 4'hf);
        write_word(5, 32'hAABBCCDD, 4'b0101);
        write_word(50, $urandom, 4'hf);
        run("t4", 1, 0, 0, -1, -1, 1'b0);
        chk("t4_b20", {56'd0, evq[20].d}, 64'hDD);
        chk("t4_b21", {56'd0, evq[21].d}, 64'h33);
        chk("t4_b22", {56'd0, evq[22].d}, 64'hBB);
        chk("t4_b23", {56'd0, evq[23].d}, 64'h11);

        // Write and start while busy are both rejected.
        randomize_model();
        run("t5", 2, 1, 1, -1, 40, 1'b0);

        // Stop in idle is forgotten; start with stop in the same cycle wins.
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        run("t6", 2, 0, 1, -1, -1, 1'b1);

        // Stop during an inter-packet gap ends the run at that slot.
        run("t7", 0, 0, 5, 190, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            randomize_model();
            run($sformatf("rnd%0d", r), $urandom_range(1, 2), $urandom_range(0, 3),
                $urandom_range(0, 4), -1, -1, 1'b0);
        end

        // Reset at byte 50 of the second packet.
        @(negedge clk);
        repeat_count = 16'd0;
        byte_div     = 8'd0;
        gap_bytes    = 8'd0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        guard = 0;
        while (cyc - t0 < 238 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("t8_pkts_before", {32'd0, packets_sent}, 64'd1);
        chk("t8_byte50", {56'd0, bus.mpeg_data}, {56'd0, model[50]});
        #2 rst_n = 1'b0;
        #1;
        chk("t8_valid", {63'd0, bus.mpeg_valid}, 64'd0);
        chk("t8_sync", {63'd0, bus.mpeg_sync}, 64'd0);
        chk("t8_data", {56'd0, bus.mpeg_data}, 64'd0);
        chk("t8_busy", {63'd0, busy}, 64'd0);
        chk("t8_packets", {32'd0, packets_sent}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mpeg_valid === 1'b1 || busy === 1'b1) nvalid++;
        end
        chk("t8_idle_after_reset", 64'(nvalid), 64'd0);
        randomize_model();
        run("t8_restart", 1, 0, 2, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
